fdiv_iter: RTL and testbench

Parametrised, iterative IEEE-754 floating-point divider with valid/ready handshakes on input and output. It is the next-generation divide unit for the FP execute path. It trades the fixed single-precision, always-busy pipeline for a radix-2 restoring-division state machine with configurable exponent and mantissa widths. It also adds full special-operand handling, round-to-nearest-even, and IEEE exception flags. One operation is in flight at a time; the FP issue logic stalls on `in_ready`.

---
 rtl/fdiv_iter_if.sv | 21 ++
 rtl/fdiv_iter.sv | 232 +++++++++++++++++++++++
 tb/tb_fdiv_iter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fdiv_iter_if.sv
// Operand/result handshake bundle for the iterative FP divider.
interface fdiv_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, result, flags);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, result, flags);
endinterface

// File: rtl/fdiv_iter.sv
// Iterative radix-2 restoring IEEE-754 divider, RNE rounding, IEEE flags.
// Define FDIV_SUBNORMAL_EN for subnormal inputs/outputs; otherwise flush-to-zero.
module fdiv_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic       clk,
  input  logic       rst,
  fdiv_iter_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int QW = MAN_W + 3;
  localparam int CW = $clog2(QW + 1);
  localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'(2**(EXP_W-1) - 1);
  localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'(2**EXP_W - 1);
  localparam logic signed [EXP_W+1:0] ONE  = (EXP_W+2)'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
`ifdef FDIV_SUBNORMAL_EN
    NORM,
`endif
    DIV, ROUND, DONE
  } state_t;

  state_t state, next;

  logic                    sign;
  logic signed [EXP_W+1:0] e;
  logic [MAN_W+1:0]        rem;
  logic [MAN_W:0]          mb;
  logic [QW-1:0]           q;
  logic [CW-1:0]           cnt;
  logic [W-1:0]            res_q;
  logic [4:0]              flg_q;

  // operand decode
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff;
  logic [MAN_W-1:0] fa, fb;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, special;
  logic signed [EXP_W+1:0] e_in;

  assign {sa, ea, fa} = bus.a;
  assign {sb, eb, fb} = bus.b;
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_snan = a_nan && !fa[MAN_W-1];
  assign b_snan = b_nan && !fb[MAN_W-1];
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
`ifdef FDIV_SUBNORMAL_EN
  logic a_sub, b_sub;
  assign a_sub  = !(|ea) && (|fa);
  assign b_sub  = !(|eb) && (|fb);
  assign a_zero = !(|ea) && !(|fa);
  assign b_zero = !(|eb) && !(|fb);
`else
  // subnormals are indistinguishable from zero in flush mode
  assign a_zero = !(|ea);
  assign b_zero = !(|eb);
`endif
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
  assign ea_eff  = (|ea) ? ea : EXP_W'(1);
  assign eb_eff  = (|eb) ? eb : EXP_W'(1);
  assign e_in    = {2'b00, ea_eff} - {2'b00, eb_eff} + BIAS;

  logic [W-1:0] sp_res;
  logic [4:0]   sp_flg;
  always_comb begin
    sp_res = '0;
    sp_flg = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_res    = QNAN;
      sp_flg[4] = a_snan | b_snan | (a_zero & b_zero) | (a_inf & b_inf);
    end else if (a_inf || b_zero) begin
      sp_res    = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      sp_flg[3] = !a_inf;
    end else begin
      sp_res = {sa ^ sb, {(W-1){1'b0}}};
    end
  end

  // one restoring step
  logic [MAN_W+2:0] diff;
  logic             ge;
  logic [MAN_W+1:0] rem_d;
  assign diff  = {1'b0, rem} - {2'b00, mb};
  assign ge    = !diff[MAN_W+2];
  assign rem_d = ge ? {diff[MAN_W:0], 1'b0} : {rem[MAN_W:0], 1'b0};

`ifdef FDIV_SUBNORMAL_EN
  // dividend shifts lower e, divisor shifts raise it
  logic [MAN_W+1:0]        rem_n;
  logic [MAN_W:0]          mb_n;
  logic signed [EXP_W+1:0] e_n;
  always_comb begin
    rem_n = rem;
    mb_n  = mb;
    e_n   = e;
    if (!rem[MAN_W]) begin
      rem_n = {rem[MAN_W:0], 1'b0};
      e_n   = e - ONE;
    end else if (!mb[MAN_W]) begin
      mb_n = {mb[MAN_W-1:0], 1'b0};
      e_n  = e + ONE;
    end
  end
`endif

  // normalise, denormalise if tiny, round to nearest even
  logic [QW-1:0]           qn, qs;
  logic signed [EXP_W+1:0] en, ef;
  logic                    tiny, lost, guard, sticky, inexact;
  logic [MAN_W:0]          mant;
  logic [MAN_W+1:0]        sum;
  logic [W-1:0]            rnd_res;
  logic [4:0]              rnd_flg;
  always_comb begin
    qn   = q[QW-1] ? q : {q[QW-2:0], 1'b0};
    en   = q[QW-1] ? e : e - ONE;
    tiny = en[EXP_W+1] || (en == '0);
    qs   = qn;
    lost = 1'b0;
`ifdef FDIV_SUBNORMAL_EN
    begin
      int sh;
      sh = 0;
      if (tiny) begin
        sh = 1 - int'(en);
        if (sh > QW) sh = QW;
        qs   = qn >> sh;
        lost = ((qs << sh) != qn);
      end
    end
`endif
    mant    = qs[QW-1:2];
    guard   = qs[1];
    sticky  = qs[0] | lost | (|rem);
    sum     = {1'b0, mant} + {{(MAN_W+1){1'b0}}, guard & (sticky | mant[0])};
    inexact = guard | sticky;
    ef      = sum[MAN_W+1] ? en + ONE : en;
    rnd_res = '0;
    rnd_flg = '0;
    if (tiny) begin
`ifdef FDIV_SUBNORMAL_EN
      // a rounding carry into the hidden bit lands on the minimum normal
      rnd_res = {sign, EXP_W'(sum[MAN_W]), sum[MAN_W-1:0]};
      rnd_flg = {3'b000, inexact, inexact};
`else
      rnd_res = {sign, {(W-1){1'b0}}};
      rnd_flg = 5'b00011;
`endif
    end else if (ef >= EMAX) begin
      rnd_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flg = 5'b00101;
    end else begin
      rnd_res = {sign, ef[EXP_W-1:0], sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0]};
      rnd_flg = {4'b0000, inexact};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (bus.in_valid) begin
`ifdef FDIV_SUBNORMAL_EN
        next = special ? DONE : ((a_sub || b_sub) ? NORM : DIV);
`else
        next = special ? DONE : DIV;
`endif
      end
`ifdef FDIV_SUBNORMAL_EN
      NORM:  if (rem_n[MAN_W] && mb_n[MAN_W]) next = DIV;
`endif
      DIV:   if (cnt == CW'(QW - 1)) next = ROUND;
      ROUND: next = DONE;
      DONE:  if (bus.out_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      flg_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sign <= sa ^ sb;
          e    <= e_in;
          rem  <= {1'b0, |ea, fa};
          mb   <= {|eb, fb};
          q    <= '0;
          cnt  <= '0;
          if (special) begin
            res_q <= sp_res;
            flg_q <= sp_flg;
          end
        end
`ifdef FDIV_SUBNORMAL_EN
        NORM: begin
          rem <= rem_n;
          mb  <= mb_n;
          e   <= e_n;
        end
`endif
        DIV: begin
          rem <= rem_d;
          q   <= {q[QW-2:0], ge};
          cnt <= cnt + CW'(1);
        end
        ROUND: begin
          res_q <= rnd_res;
          flg_q <= rnd_flg;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign bus.flags     = flg_q;
endmodule

// File: tb/tb_fdiv_iter.sv
// Directed-vector bench for fdiv_iter (single precision), hand-computed expectations.
module tb_fdiv_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fdiv_iter_if #(.EXP_W(8), .MAN_W(23)) bus ();
  fdiv_iter #(.EXP_W(8), .MAN_W(23)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [31:0] op_a, input logic [31:0] op_b);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin tick(); n++; end
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    bus.a        = op_a;
    bus.b        = op_b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin tick(); lat++; end
  endtask

  task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] er, input logic [4:0] ef, input int el);
    int lat;
    issue(tag, op_a, op_b);
    wait_out(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(el));
    chk({tag, "_res"}, bus.result, er);
    chk({tag, "_flg"}, 32'(bus.flags), 32'(ef));
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    bit stable;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_result",    bus.result,         32'd0);
    chk("rst_flags",     32'(bus.flags),     32'd0);

    run_op("six_two",  32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28);
    chk("after_handshake_ovld", 32'(bus.out_valid), 32'd0);
    run_op("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 28);
    run_op("neg_six",  32'hC0C00000, 32'h40000000, 32'hC0400000, 5'h00, 28);
    run_op("div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 1);
    run_op("zero_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 5'h10, 1);
    run_op("snan",     32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'h10, 1);
    run_op("qnan",     32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'h00, 1);
    run_op("inf_fin",  32'hFF800000, 32'h40000000, 32'hFF800000, 5'h00, 1);
    run_op("fin_inf",  32'h40000000, 32'hFF800000, 32'h80000000, 5'h00, 1);
    run_op("overflow", 32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 5'h05, 28);
`ifdef FDIV_SUBNORMAL_EN
    run_op("tiny",     32'h00800000, 32'h40000000, 32'h00400000, 5'h00, 28);
    run_op("sub_in",   32'h00400000, 32'h3F800000, 32'h00400000, 5'h00, 29);
`else
    run_op("tiny",     32'h00800000, 32'h40000000, 32'h00000000, 5'h03, 28);
    run_op("sub_in",   32'h00400000, 32'h3F800000, 32'h00000000, 5'h00, 1);
`endif

    // stall the consumer, poke in_valid while busy
    bus.out_ready = 1'b0;
    issue("hold", 32'h3F800000, 32'h40400000);
    bus.a = 32'h40C00000;
    bus.in_valid = 1'b1;
    wait_out(lat);
    chk("hold_lat", 32'(lat), 32'd28);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.result !== 32'h3EAAAAAB || bus.flags !== 5'h01 ||
          bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) stable = 1'b0;
      tick();
    end
    chk("hold_stable", 32'(stable), 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("hold_release_rdy", 32'(bus.in_ready), 32'd1);

    // abort mid-division
    issue("abort", 32'h40C00000, 32'h40000000);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
    run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
